// File: rtl/rx_frame_unpacker.sv
// Captures a fixed-size receive frame, validates its length header (and, when
// RX_CHECKSUM_EN is defined, an XOR checksum), then streams the payload bytes.
module rx_frame_unpacker #(
  parameter int FRAME_BYTES = 15,
  parameter int CNT_W       = 8
) (
  input  logic                     Mclk,
  input  logic                     nReset,
  input  logic [8*FRAME_BYTES-1:0] frame_in,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  output logic [7:0]               byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic                     byte_last,
  output logic                     frame_err,
  output logic                     frame_drop,
  output logic [CNT_W-1:0]         frame_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [1:0]               state_dbg
);

  // Byte stream handshake: a byte transfers on every rising edge where
  // byte_valid & byte_ready; byte_out/byte_last/byte_valid are held until then.

`ifdef RX_CHECKSUM_EN
  localparam int MAX_L = FRAME_BYTES - 2;
`else
  localparam int MAX_L = FRAME_BYTES - 1;
`endif
  localparam logic [7:0]       MAX_L_B = 8'(MAX_L);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [8*FRAME_BYTES-1:0] buf_q;
  logic [7:0]               idx_q, idx_d;
  logic [7:0]               len;
  logic                     len_ok, csum_ok;
  logic                     load_buf, accept, reject, advance, done, drop_evt;
  logic [7:0]               sel_byte;
  logic [1:0]               err_inc;
  logic [CNT_W:0]           err_sum;

  logic [7:0]               byte_out_q;
  logic                     byte_valid_q, byte_last_q, frame_err_q, frame_drop_q;
  logic [CNT_W-1:0]         frame_cnt_q, err_cnt_q;

  assign len    = buf_q[7:0];
  assign len_ok = (len != 8'd0) && (len <= MAX_L_B);

`ifdef RX_CHECKSUM_EN
  logic [7:0] csum_calc, csum_rx;

  // Checksum covers the length byte and the payload; it sits right after the payload.
  always_comb begin
    csum_calc = '0;
    csum_rx   = '0;
    for (int k = 0; k < FRAME_BYTES; k++) begin
      if (k <= int'(len))     csum_calc = csum_calc ^ buf_q[8*k +: 8];
      if (k == int'(len) + 1) csum_rx   = buf_q[8*k +: 8];
    end
  end
  assign csum_ok = (csum_calc == csum_rx);
`else
  assign csum_ok = 1'b1;
`endif

  always_ff @(posedge Mclk or negedge nReset) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    load_buf = 1'b0;
    accept   = 1'b0;
    reject   = 1'b0;
    advance  = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_valid) begin
          load_buf = 1'b1;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (len_ok && csum_ok) begin
          accept  = 1'b1;
          idx_d   = 8'd1;
          state_d = EMIT;
        end else begin
          reject  = 1'b1;
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (byte_ready) begin
          if (idx_q == len) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            advance = 1'b1;
            idx_d   = idx_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign drop_evt = frame_valid && (state_q != IDLE);

  // Byte registered for the next cycle is selected by the upcoming index.
  always_comb begin
    sel_byte = '0;
    for (int k = 0; k < FRAME_BYTES; k++) begin
      if (k == int'(idx_d)) sel_byte = buf_q[8*k +: 8];
    end
  end

  assign err_inc = {1'b0, reject} + {1'b0, drop_evt};
  assign err_sum = {1'b0, err_cnt_q} + (CNT_W+1)'(err_inc);

  always_ff @(posedge Mclk or negedge nReset) begin
    if (!nReset) begin
      buf_q        <= '0;
      idx_q        <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_drop_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      if (load_buf) buf_q <= frame_in;
      idx_q        <= idx_d;
      frame_err_q  <= reject;
      frame_drop_q <= drop_evt;
      if (accept || advance) begin
        byte_out_q   <= sel_byte;
        byte_valid_q <= 1'b1;
        byte_last_q  <= (idx_d == len);
      end else if (done) begin
        byte_valid_q <= 1'b0;
        byte_last_q  <= 1'b0;
      end
      if (done && (frame_cnt_q != CNT_MAX)) frame_cnt_q <= frame_cnt_q + 1'b1;
      err_cnt_q <= err_sum[CNT_W] ? CNT_MAX : err_sum[CNT_W-1:0];
    end
  end

  assign frame_ready = (state_q == IDLE);
  assign byte_out    = byte_out_q;
  assign byte_valid  = byte_valid_q;
  assign byte_last   = byte_last_q;
  assign frame_err   = frame_err_q;
  assign frame_drop  = frame_drop_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_rx_frame_unpacker.sv
// Bench for rx_frame_unpacker: vector table, saturation runs, reset abort and
// randomized frames checked against a payload-queue reference model.
module tb_rx_frame_unpacker;

  localparam int FB    = 15;
  localparam int FW    = 8 * FB;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef RX_CHECKSUM_EN
  localparam int MAXL = FB - 2;
`else
  localparam int MAXL = FB - 1;
`endif

  logic             Mclk;
  logic             nReset;
  logic [FW-1:0]    frame_in;
  logic             frame_valid;
  logic             frame_ready;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready;
  logic             byte_last;
  logic             frame_err;
  logic             frame_drop;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [1:0]       state_dbg;

  rx_frame_unpacker #(.FRAME_BYTES(FB), .CNT_W(CNT_W)) dut (
    .Mclk(Mclk), .nReset(nReset), .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .byte_last(byte_last), .frame_err(frame_err),
    .frame_drop(frame_drop), .frame_cnt(frame_cnt), .err_cnt(err_cnt),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial Mclk = 1'b0;
  always #5 Mclk = ~Mclk;

  int errors = 0;
  int checks = 0;
  int exp_frames = 0;
  int exp_errs   = 0;

  typedef struct {
    int         len;
    logic [7:0] base;
    logic       csum_bad;
    int         ready_pct;
    int         drop_c;
    int         stall_at;
    logic       exp_acc;
    int         exp_ret;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Mclk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic [7:0] fbyte(input logic [FW-1:0] f, input int k);
    return f[8*k +: 8];
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < FB; k++) f[8*k +: 8] = 8'($urandom_range(255));
    return f;
  endfunction

  function automatic logic [7:0] xor_upto(input logic [FW-1:0] f, input int l);
    logic [7:0] x = 8'h00;
    for (int k = 0; k <= l; k++) x = x ^ f[8*k +: 8];
    return x;
  endfunction

  function automatic logic [FW-1:0] build_frame(input int l, input logic [7:0] base,
                                                input logic bad);
    logic [FW-1:0] f = rand_frame();
    f[7:0] = 8'(l);
    for (int k = 1; k <= l && k < FB; k++) f[8*k +: 8] = base + 8'(k * 17);
`ifdef RX_CHECKSUM_EN
    if (l + 1 < FB) f[8*(l+1) +: 8] = xor_upto(f, l) ^ {7'b0, bad};
`else
    if (bad) f = f;
`endif
    return f;
  endfunction

  // Reference acceptance rule straight from the frame format.
  function automatic logic model_accept(input logic [FW-1:0] f);
    int  l  = int'(f[7:0]);
    logic ok = (l >= 1) && (l <= MAXL);
`ifdef RX_CHECKSUM_EN
    if (ok) ok = (fbyte(f, l + 1) == xor_upto(f, l));
`endif
    return ok;
  endfunction

  // Sends one frame from IDLE and checks every cycle until the block is idle again.
  task automatic run_frame(input logic [FW-1:0] f, input logic acc, input int ready_pct,
                           input int drop_c, input int stall_at, input int exp_ret);
    logic [7:0] exp_q[$];
    int   c, p, stall_left;
    logic drop_pend, done;
    chk("ready_at_start", 32'(frame_ready), 32'd1);
    if (acc) for (int k = 1; k <= int'(f[7:0]); k++) exp_q.push_back(fbyte(f, k));
    if (acc) exp_frames = sat(exp_frames);
    else     exp_errs   = sat(exp_errs);
    frame_in = f;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    c = 1; p = 0; stall_left = 4; drop_pend = 1'b0; done = 1'b0;
    while (!done) begin
      chk("frame_drop", 32'(frame_drop), 32'(drop_pend));
      drop_pend = 1'b0;
      chk("frame_err", 32'(frame_err), 32'(!acc && c == 2));
      byte_ready = ($urandom_range(99) < ready_pct);
      if (p + 1 == stall_at && stall_left > 0) begin
        byte_ready = 1'b0;
        stall_left--;
      end
      if (byte_valid) begin
        if (exp_q.size() == 0) chk("spurious_byte", 32'd1, 32'd0);
        else begin
          chk("byte_out", 32'(byte_out), 32'(exp_q[0]));
          chk("byte_last", 32'(byte_last), 32'(exp_q.size() == 1));
          if (byte_ready) begin
            void'(exp_q.pop_front());
            p++;
          end
        end
      end else begin
        chk("byte_last_idle", 32'(byte_last), 32'd0);
      end
      if (frame_ready && c >= 2 && exp_q.size() == 0) begin
        done = 1'b1;
        if (exp_ret != 0) chk("ready_return_cycle", 32'(c), 32'(exp_ret));
      end else if (c > 300) begin
        chk("timeout", 32'd1, 32'd0);
        done = 1'b1;
      end else begin
        if (c == drop_c && !frame_ready) begin
          frame_in    = rand_frame();
          frame_valid = 1'b1;
          drop_pend   = 1'b1;
          exp_errs    = sat(exp_errs);
        end
        tick();
        frame_valid = 1'b0;
        c++;
      end
    end
    byte_ready = 1'b0;
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    chk("err_cnt", 32'(err_cnt), 32'(exp_errs));
    chk("byte_valid_end", 32'(byte_valid), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_frame_ready"}, 32'(frame_ready), 32'd1);
    chk({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
    chk({tag, "_byte_last"}, 32'(byte_last), 32'd0);
    chk({tag, "_byte_out"}, 32'(byte_out), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_frame_drop"}, 32'(frame_drop), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  initial begin
    logic [FW-1:0] f;
    int            l;

    // len, base, csum_bad, ready_pct, drop_c, stall_at, exp_acc, exp_ret
    tbl.push_back('{3,        8'h90, 1'b0, 100, -1, 0, 1'b1, 5});
    tbl.push_back('{3,        8'h90, 1'b0, 100, -1, 2, 1'b1, 9});
    tbl.push_back('{0,        8'h10, 1'b0, 100, -1, 0, 1'b0, 2});
    tbl.push_back('{15,       8'h10, 1'b0, 100, -1, 0, 1'b0, 2});
    tbl.push_back('{MAXL,     8'h05, 1'b0, 100,  5, 0, 1'b1, MAXL + 2});
    tbl.push_back('{MAXL + 1, 8'h07, 1'b0, 100, -1, 0, 1'b0, 2});
    tbl.push_back('{1,        8'h55, 1'b0, 100, -1, 0, 1'b1, 3});
    tbl.push_back('{5,        8'h20, 1'b0, 100,  1, 0, 1'b1, 7});
    tbl.push_back('{0,        8'h20, 1'b0, 100,  1, 0, 1'b0, 2});
    tbl.push_back('{6,        8'h40, 1'b0,  50,  3, 0, 1'b1, 0});
`ifdef RX_CHECKSUM_EN
    tbl.push_back('{2,        8'h00, 1'b0, 100, -1, 0, 1'b1, 4});
    tbl.push_back('{2,        8'h00, 1'b1, 100, -1, 0, 1'b0, 2});
`endif

    nReset      = 1'b0;
    frame_in    = '0;
    frame_valid = 1'b0;
    byte_ready  = 1'b0;
    repeat (2) tick();
    check_reset_values("reset");
    @(negedge Mclk);
    nReset = 1'b1;
    tick();

    foreach (tbl[i]) begin
      f = build_frame(tbl[i].len, tbl[i].base, tbl[i].csum_bad);
      run_frame(f, tbl[i].exp_acc, tbl[i].ready_pct, tbl[i].drop_c,
                tbl[i].stall_at, tbl[i].exp_ret);
    end

    // Drive both counters into saturation.
    for (int i = 0; i < CMAX + 3; i++) run_frame(build_frame(1, 8'(i), 1'b0), 1'b1, 100, -1, 0, 3);
    for (int i = 0; i < CMAX + 3; i++) run_frame(build_frame(0, 8'(i), 1'b0), 1'b0, 100, -1, 0, 2);

    // Asynchronous reset while the second payload byte is on the bus.
    f = build_frame(4, 8'h30, 1'b0);
    frame_in    = f;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    byte_ready  = 1'b1;
    tick();
    tick();
    chk("pre_reset_byte2", 32'(byte_out), 32'(fbyte(f, 2)));
    nReset = 1'b0;
    #1;
    check_reset_values("async_reset");
    byte_ready = 1'b0;
    @(negedge Mclk);
    nReset = 1'b1;
    tick();
    exp_frames = 0;
    exp_errs   = 0;
    run_frame(build_frame(4, 8'h61, 1'b0), 1'b1, 100, -1, 0, 6);

    // Randomized frames against the reference acceptance rule.
    for (int i = 0; i < 40; i++) begin
      l = int'($urandom_range(0, 15));
      f = rand_frame();
      f[7:0] = 8'(l);
`ifdef RX_CHECKSUM_EN
      if (l + 1 < FB && $urandom_range(3) != 0) f[8*(l+1) +: 8] = xor_upto(f, l);
`endif
      run_frame(f, model_accept(f), int'($urandom_range(30, 100)),
                int'($urandom_range(0, 8)), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
